// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FSM state encoding, the bubble instruction and RV32 field positions.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory read port: single-outstanding request/response.
// master = fetch side (req, addr out; rvalid, rdata in), slave = memory.
interface fetch_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc,instr} holding register for a response that found IF/ID full.
// Ports: clk, rst, load, clear, pc_in, instr_in -> full, pc, instr.
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic            full,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      full  <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register of the 3-stage RV32 core.
// Ports: clk, rst, pc_en, stall, br_taken, br_target, imem (master),
//        if_valid, if_pc, if_instr, opcode, funct3, funct7.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  fetch_if.master         imem,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            ifv_d;
  logic [XLEN-1:0] ifpc_d;
  logic [31:0]     ifins_d;

  logic            consume, ifid_free, issue;
  logic [XLEN-1:0] pc_inc, tgt;

  logic            skid_load, skid_clear, skid_full;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .pc_in    (pc_q),
    .instr_in (imem.imem_rdata),
    .full     (skid_full),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

  assign consume   = if_valid & ~stall & pc_en;
  assign ifid_free = ~if_valid | consume;
  assign issue     = (state_q == FETCH) & ~br_taken
                   & pc_en & ~rst;
  assign pc_inc    = pc_q + XLEN'(4);
  assign tgt       = br_target & ~XLEN'(3);

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_q;

  // if_instr holds NOP whenever if_valid=0,
  // so the slices decode a bubble then
  assign opcode = if_instr[OPC_MSB:OPC_LSB];
  assign funct3 = if_instr[F3_MSB:F3_LSB];
  assign funct7 = if_instr[F7_MSB:F7_LSB];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    ifv_d      = if_valid;
    ifpc_d     = if_pc;
    ifins_d    = if_instr;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (consume) begin
      ifv_d   = 1'b0;
      ifins_d = NOP_INSTR;
    end

    if (br_taken) begin
      pc_d       = tgt;
      ifv_d      = 1'b0;
      ifins_d    = NOP_INSTR;
      skid_clear = 1'b1;
      state_d    = FETCH;
      kill_d     = 1'b0;
      // request still in flight: swallow its
      // response before fetching the target
      if (state_q == WAIT && !imem.imem_rvalid) begin
        kill_d  = 1'b1;
        state_d = WAIT;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (issue) state_d = WAIT;
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = FETCH;
            end else if (ifid_free) begin
              ifv_d   = 1'b1;
              ifpc_d  = pc_q;
              ifins_d = imem.imem_rdata;
              pc_d    = pc_inc;
              state_d = FETCH;
            end else begin
              skid_load = 1'b1;
              pc_d      = pc_inc;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (ifid_free && skid_full) begin
            ifv_d      = 1'b1;
            ifpc_d     = skid_pc;
            ifins_d    = skid_instr;
            skid_clear = 1'b1;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_instr <= NOP_INSTR;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      if_valid <= ifv_d;
      if_pc    <= ifpc_d;
      if_instr <= ifins_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage and IF/ID pipeline register of the 3-stage RISC-V core; sits directly upstream of the decode controller. Owns the PC and issues single-outstanding requests to a variable-latency instruction memory. Buffers the returned word in the IF/ID register and exposes the opcode/funct3/funct7 slices the controller decodes. Handles back-pressure (stall, PCen) and branch redirect/flush.

Parameters:
XLEN, 32, PC and data width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, ADDI x0,x0,0 bubble instruction placed in IF/ID on reset/flush

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
pc_en  input  1  PCen from the controller; 0 blocks consumption of IF/ID and new fetch issue
stall  input  1  hazard stall from the downstream stage; 1 = IF/ID entry not consumed this cycle
br_taken  input  1  redirect request from execute
br_target  input  XLEN  redirect target, word aligned
imem_req  output  1  instruction read request, one-cycle pulse
imem_addr  output  XLEN  request address (= PC)
imem_rvalid  input  1  read data valid, one cycle, >=1 cycle after imem_req
imem_rdata  input  32  instruction word
if_valid  output  1  IF/ID entry holds a real instruction
if_pc  output  XLEN  PC of IF/ID instruction
if_instr  output  32  IF/ID instruction
opcode  output  7  if_instr[6:0]
funct3  output  3  if_instr[14:12]
funct7  output  7  if_instr[31:25]

Behaviour:
- Reset (async, while rst=1): pc=RESET_PC, state=FETCH, kill=0, skid empty, if_valid=0, if_pc=RESET_PC, if_instr=NOP_INSTR; imem_req=0. First request in the first cycle after rst deasserts.
- consume = if_valid & ~stall & pc_en. IF/ID free = ~if_valid | consume. On consume with no new load, if_valid<=0 and if_instr<=NOP_INSTR.
- opcode/funct3/funct7 are combinational slices of if_instr; when if_valid=0 they decode NOP (0010011/000/0000000).
- FSM states FETCH, WAIT, HOLD:
  - FETCH: imem_req = ~br_taken & pc_en; imem_addr=pc. If request issued -> WAIT; else stay.
  - WAIT: imem_req=0. On imem_rvalid: if kill=1 -> drop data, kill<=0, -> FETCH. Else if IF/ID free -> load if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, -> FETCH. Else -> write skid {pc,rdata}, pc<=pc+4, -> HOLD.
  - HOLD: when IF/ID free -> move skid into IF/ID (if_valid<=1), skid empty, -> FETCH.
- Redirect (br_taken=1) has highest priority in every state: pc<=br_target; if_valid<=0, if_instr<=NOP_INSTR; skid emptied; next state FETCH. If in WAIT and imem_rvalid=0 this cycle, kill<=1 and stay WAIT until the stale response returns (then FETCH). If in WAIT with imem_rvalid=1 same cycle, data dropped, -> FETCH.
- Simultaneous consume and load: load wins; if_valid stays 1.
- At most one outstanding request; imem_req never asserted in WAIT/HOLD.
- PC arithmetic: pc+4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000). br_target[1:0] ignored (forced 0).
- Throughput: 1-cycle memory latency gives one instruction every 2 cycles.

Decomposition:
- Package fetch_pkg: state enum (FETCH, WAIT, HOLD), NOP_INSTR constant, RV32 field bit-position constants.
- One sub-module: fetch_skid_buf (1-entry {pc,instr} register with load/clear/full).

Test Plan:
- Reset release, memory latency 1, imem_rdata=0x00500093 -> imem_req at cycle 1 addr 0x0; if_valid=1, if_instr=0x00500093, opcode=0010011 two cycles later; next request addr 0x4.
- stall=1 for 5 cycles while WAIT returns 0x002081B3 with IF/ID full -> state HOLD, no imem_req; on stall drop, IF/ID gets 0x002081B3, if_pc=0x8.
- br_taken with br_target=0x100 while WAIT, response 3 cycles later -> response dropped, if_valid=0, next imem_addr=0x100.
- br_taken same cycle as imem_rvalid -> data dropped, if_instr=NOP_INSTR, next imem_addr=br_target.
- pc=0xFFFF_FFFC fetch completes -> next imem_addr=0x0000_0000.
- rst asserted mid-WAIT -> outputs return to reset values immediately; late imem_rvalid after release ignored until first new request.
